// File: rtl/crypt_dec_arbiter_pkg.sv
// Shared types and widths for the crypt_dec_arbiter block.
package crypt_arb_pkg;

    localparam int BLOCK_W      = 128;
    localparam int KEY_W        = 6;
    localparam int DEF_CORE_LAT = 15;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        CAPT,
        RESP
    } arb_state_e;

endpackage

// File: rtl/crypt_dec_arbiter_if.sv
// Requester-side job/result bus of crypt_dec_arbiter (master = requesters, slave = arbiter).
interface crypt_dec_arbiter_if #(
    parameter int NUM_REQ = 2
);
    import crypt_arb_pkg::*;

    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*BLOCK_W-1:0] req_data;
    logic [NUM_REQ*KEY_W-1:0]   req_key;
    logic [NUM_REQ-1:0]         resp_valid;
    logic [NUM_REQ-1:0]         resp_ready;
    logic [BLOCK_W-1:0]         resp_data;

    modport master (
        output req_valid, req_data, req_key, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_data, req_key, resp_ready,
        output req_ready, resp_valid, resp_data
    );

endinterface

// File: rtl/crypt_dec_arbiter_rr.sv
// Combinational round-robin picker: first requester with valid set, searching upward from rr_ptr.
module crypt_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W:0]   pos;
    logic [IDX_W-1:0] idx;
    logic             found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = '0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // rr_ptr + k folded back into 0..NUM_REQ-1 without a divider
            pos = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
            if (pos >= (IDX_W + 1)'(NUM_REQ)) begin
                pos = pos - (IDX_W + 1)'(NUM_REQ);
            end
            idx = pos[IDX_W-1:0];
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/crypt_dec_arbiter.sv
// Shares one pipelined decrypt core among NUM_REQ requesters, one job at a time.
// Optional per-requester completed-job counters behind CRYPT_DEC_ARB_STATS_EN.
module crypt_dec_arbiter
    import crypt_arb_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int CORE_LAT = DEF_CORE_LAT
) (
    input  logic                   clk,
    input  logic                   reset_n,
    crypt_dec_arbiter_if.slave     bus,
    output logic [BLOCK_W-1:0]     core_din,
    output logic [KEY_W-1:0]       core_key,
    output logic                   core_enable,
    output logic                   core_reset,
    input  logic [BLOCK_W-1:0]     core_dout,
    output logic                   busy
`ifdef CRYPT_DEC_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]  job_count
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(CORE_LAT) + 1;

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   gnt_id_q, gnt_id_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BLOCK_W-1:0] din_q, din_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [BLOCK_W-1:0] resp_data_q, resp_data_d;
    logic               core_reset_q, core_reset_d;
    logic               core_enable_q, core_enable_d;

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               req_fire;
    logic               resp_fire;

    crypt_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req       (bus.req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_fire  = (state_q == IDLE) && (|grant);
    assign resp_fire = (state_q == RESP) && bus.resp_ready[gnt_id_q];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            gnt_id_q      <= '0;
            cnt_q         <= '0;
            din_q         <= '0;
            key_q         <= '0;
            resp_data_q   <= '0;
            core_reset_q  <= 1'b1;
            core_enable_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            gnt_id_q      <= gnt_id_d;
            cnt_q         <= cnt_d;
            din_q         <= din_d;
            key_q         <= key_d;
            resp_data_q   <= resp_data_d;
            core_reset_q  <= core_reset_d;
            core_enable_q <= core_enable_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_fire) state_d = LOAD;
            LOAD:    state_d = RUN;
            RUN:     if (cnt_q == CNT_W'(CORE_LAT - 1)) state_d = CAPT;
            CAPT:    state_d = RESP;
            RESP:    if (resp_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        gnt_id_d    = gnt_id_q;
        din_d       = din_q;
        key_d       = key_q;
        cnt_d       = cnt_q;
        resp_data_d = resp_data_q;
        if (req_fire) begin
            gnt_id_d = grant_idx;
            rr_ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i]) begin
                    din_d = bus.req_data[i*BLOCK_W +: BLOCK_W];
                    key_d = bus.req_key[i*KEY_W +: KEY_W];
                end
            end
        end
        if (state_q == LOAD) cnt_d = '0;
        if (state_q == RUN)  cnt_d = cnt_q + 1'b1;
        if (state_q == CAPT) resp_data_d = core_dout;
        // Core controls are registered from the upcoming state so they line up with LOAD/RUN exactly
        core_reset_d  = (state_d == LOAD);
        core_enable_d = (state_d == RUN);
    end

    always_comb begin
        bus.req_ready  = '0;
        bus.resp_valid = '0;
        // reset_n gates the combinational grant so req_ready is quiet while reset is held
        if (state_q == IDLE && reset_n) bus.req_ready = grant;
        if (state_q == RESP) bus.resp_valid[gnt_id_q] = 1'b1;
    end

    assign bus.resp_data = resp_data_q;
    assign core_din      = din_q;
    assign core_key      = key_q;
    assign core_reset    = core_reset_q;
    assign core_enable   = core_enable_q;
    assign busy          = (state_q != IDLE);

`ifdef CRYPT_DEC_ARB_STATS_EN
    logic [15:0] job_cnt_q [NUM_REQ];
    logic [15:0] job_cnt_d [NUM_REQ];

    always_comb begin
        job_cnt_d = job_cnt_q;
        if (resp_fire) job_cnt_d[gnt_id_q] = job_cnt_q[gnt_id_q] + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REQ; i++) job_cnt_q[i] <= '0;
        end else begin
            job_cnt_q <= job_cnt_d;
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_job_count
        assign job_count[g*16 +: 16] = job_cnt_q[g];
    end
`endif

endmodule
